// File: rtl/convolution_processor_ctrl.sv
// rtl/convolution_processor_ctrl.sv - sequencing and MAC stage computing Z = X * Y into memZ
//
// Purpose: walks output index i and Y index j over two synchronous-read
// memories, accumulates X[i-j]*Y[j] for in-range pairs and writes one
// accumulated result per output to memZ, with a start/busy/done handshake.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      run request, sampled only in IDLE
//   sizeX_i      length of X (clamped to 2**ADDR_WIDTH), latched at start
//   sizeY_i      length of Y (clamped to 2**ADDR_WIDTH), latched at start
//   dataX_i      memX read data, one cycle after memX_addr_o
//   dataY_i      memY read data, one cycle after memY_addr_o
//   memX_addr_o  memX read address (i - j)
//   memY_addr_o  memY read address (j)
//   memZ_addr_o  memZ write address (i)
//   memZ_we_o    memZ write strobe
//   dataZ_o      accumulator value, written to memZ
//   busy_o       high outside IDLE
//   done_o       one-cycle completion pulse
module convolution_processor_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [ADDR_WIDTH:0]               sizeX_i,
  input  logic [ADDR_WIDTH:0]               sizeY_i,
  input  logic [DATA_WIDTH-1:0]             dataX_i,
  input  logic [DATA_WIDTH-1:0]             dataY_i,
  output logic [ADDR_WIDTH-1:0]             memX_addr_o,
  output logic [ADDR_WIDTH-1:0]             memY_addr_o,
  output logic [ADDR_WIDTH:0]               memZ_addr_o,
  output logic                              memZ_we_o,
  output logic [2*DATA_WIDTH+ADDR_WIDTH-1:0] dataZ_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int AW   = ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int ACCW = 2*DW + AW;

  localparam logic [AW:0]   MAX_SIZE = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] J_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW+1:0] TWO      = (AW+2)'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INNER,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [AW:0]     r_size_x;
  logic [AW:0]     r_size_y;
  logic [AW:0]     r_i;
  logic [AW-1:0]   r_j;
  logic [ACCW-1:0] r_acc;
  logic            r_valid_q;

  logic [AW:0]     w_sx_clamped;
  logic [AW:0]     w_sy_clamped;
  logic [AW:0]     w_diff;
  logic            w_in_range;
  logic            w_j_last;
  logic            w_i_last;
  logic [2*DW-1:0] w_prod;
  logic            w_idle;

  assign w_sx_clamped = (sizeX_i > MAX_SIZE) ? MAX_SIZE : sizeX_i;
  assign w_sy_clamped = (sizeY_i > MAX_SIZE) ? MAX_SIZE : sizeY_i;

  // i - j is only meaningful when j <= i; otherwise the wrapped value is
  // still driven as the X address but the product is discarded.
  assign w_diff     = r_i - {1'b0, r_j};
  assign w_in_range = ({1'b0, r_j} <= r_i) && (w_diff < r_size_x);
  assign w_j_last   = ({1'b0, r_j} == (r_size_y - ONE));
  // Last output index is sX + sY - 2; one extra bit keeps the sum exact.
  assign w_i_last   = ({1'b0, r_i} == ({1'b0, r_size_x} + {1'b0, r_size_y} - TWO));
  assign w_prod     = {{DW{1'b0}}, dataX_i} * {{DW{1'b0}}, dataY_i};
  assign w_idle     = (r_state == S_IDLE);

  assign memY_addr_o = w_idle ? '0 : r_j;
  assign memX_addr_o = w_idle ? '0 : w_diff[AW-1:0];
  assign memZ_addr_o = w_idle ? '0 : r_i;
  assign memZ_we_o   = (r_state == S_WRITE);
  assign dataZ_o     = r_acc;
  assign busy_o      = !w_idle;
  assign done_o      = (r_state == S_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if ((w_sx_clamped == '0) || (w_sy_clamped == '0)) begin
            w_next = S_DONE;
          end else begin
            w_next = S_INNER;
          end
        end
      end
      S_INNER: begin
        if (w_j_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: w_next = w_i_last ? S_DONE : S_INNER;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_size_x  <= '0;
      r_size_y  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_valid_q <= 1'b0;
    end else begin
      // Read data lands one cycle after its address, so the accumulate
      // enable is the issue-cycle range check delayed by one.
      r_valid_q <= (r_state == S_INNER) && w_in_range;

      if (r_valid_q) begin
        r_acc <= r_acc + {{AW{1'b0}}, w_prod};
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_size_x <= w_sx_clamped;
            r_size_y <= w_sy_clamped;
            r_i      <= '0;
            r_j      <= '0;
            r_acc    <= '0;
          end
        end
        S_INNER: begin
          if (!w_j_last) begin
            r_j <= r_j + J_ONE;
          end
        end
        S_WRITE: begin
          if (!w_i_last) begin
            r_i   <= r_i + ONE;
            r_j   <= '0;
            r_acc <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/convolution_processor_ctrl.md
# convolution_processor_ctrl

Sequencing and multiply-accumulate stage of the convolution processor. It computes Z = X ∗ Y (full linear convolution) over two external synchronous-read memories and writes each result to memZ. The unsigned less-than comparators sit on its loop-bound and range-check paths and consume its counter values. A start/busy/done handshake connects it to the host-side register interface.

## Interface
- DATA_WIDTH, default 8: width of one X or Y sample, unsigned.
- ADDR_WIDTH, default 5: memX/memY address width. Maximum length of each operand is 2**ADDR_WIDTH.
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- start_i  in  1  starts a run. Sampled only in IDLE.
- sizeX_i  in  ADDR_WIDTH+1  length of X. Latched at start.
- sizeY_i  in  ADDR_WIDTH+1  length of Y. Latched at start.
- dataX_i  in  DATA_WIDTH  memX read data. Valid one cycle after its address.
- dataY_i  in  DATA_WIDTH  memY read data. Valid one cycle after its address.
- memX_addr_o  out  ADDR_WIDTH  memX read address.
- memY_addr_o  out  ADDR_WIDTH  memY read address.
- memZ_addr_o  out  ADDR_WIDTH+1  memZ write address.
- memZ_we_o  out  1  memZ write strobe.
- dataZ_o  out  2*DATA_WIDTH+ADDR_WIDTH  memZ write data, which is the accumulator value.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

## Operation
- **Reset:** on reset, the FSM goes to IDLE. All outputs, counters, the accumulator and valid_q are 0.
- **Size latching:** at start, each size is latched and clamped to at most 2**ADDR_WIDTH. Let N = sX + sY − 1.
- **Counters:**
  - i is the output index, ADDR_WIDTH+1 bits.
  - j is the Y index, ADDR_WIDTH bits.
  - memY_addr_o = j.
  - memX_addr_o = (i − j) truncated to ADDR_WIDTH.
  - memZ_addr_o = i.
  - In IDLE all addresses are 0.
- **Range check:** in_range = (j ≤ i) AND ((i − j) < sX). When in_range is 0, the address is still driven but the product is discarded.
- **Read pipeline:** valid_q ← (state == INNER) AND in_range, registered.
- **Accumulate:** whenever valid_q = 1, acc ← acc + dataX_i*dataY_i.
  - Products are unsigned, 2*DATA_WIDTH bits wide.
  - acc is unsigned, 2*DATA_WIDTH+ADDR_WIDTH bits wide, and cannot overflow at legal sizes.
- **FSM states:**
  - IDLE:
    - start_i with sX = 0 or sY = 0 → DONE, with no memZ writes.
    - start_i with both sizes nonzero → INNER, with i = 0, j = 0, acc = 0.
  - INNER: one issue per cycle. j increments each cycle. When j == sY−1 → DRAIN.
  - DRAIN: one cycle, in which the last product accumulates.
  - WRITE: memZ_we_o = 1, dataZ_o = acc, memZ_addr_o = i.
    - If i == N−1 → DONE.
    - Otherwise i++, j = 0, acc cleared, → INNER.
  - DONE: done_o = 1 for one cycle, then → IDLE.
- **Write strobe:** memZ_we_o is high only in WRITE.
- **Data output:** dataZ_o equals acc at all times. It is meaningful only while memZ_we_o is high.
- **start_i outside IDLE** is ignored. Size inputs are not re-sampled mid-run.
- **Reset mid-run** aborts immediately. No further writes occur, and the next start_i starts a clean run.

## Timing
- **Start acceptance:** start is accepted on clock edge E0. Cycle 1 is the cycle following E0.
- **Per-output cost:** each output costs sY + 2 cycles (INNER ×sY, DRAIN, WRITE).
- **Completion:** done_o is high in cycle N*(sY+2)+1 and low otherwise.
- **Zero-size run:** done_o is high in cycle 1.
- **busy_o:** rises in cycle 1 and falls the cycle after done_o. busy_o and done_o are both high in the DONE cycle.
- **Back-to-back runs:** start_i held high across done re-triggers on the first IDLE cycle, so there is at least one IDLE cycle between runs.
- **Memory latency:** the memory must return data exactly one cycle after the address, with no stalls. There is no backpressure on memZ.
- **Write ordering:** memZ writes occur in ascending i, one per output, with no gaps in addresses 0..N−1.

## Test plan
- **Basic convolution:** sX=3, X=[1,2,3]; sY=2, Y=[1,1].
  - memZ writes = [1,3,5,3] at addresses 0..3.
  - done_o in cycle 17, busy_o high in cycles 1–17.
- **Minimum size:** sX=sY=1, X=[7], Y=[9].
  - A single write of 63 at address 0, in cycle 3.
  - done_o in cycle 4.
- **Maximum size, all-ones data:** sX=sY=32, all samples 255.
  - Z[0]=65025, Z[31]=2080800, Z[62]=65025.
  - 63 writes, done_o in cycle 63*34+1 = 2143.
- **Zero size:** sX=0, sY=5.
  - No memZ_we_o pulses, done_o in cycle 1.
  - sX=33 is clamped to 32.
- **Start while busy:** pulse start_i with new sizes in the middle of a run.
  - Results and done timing are identical to an undisturbed run.
- **Reset mid-run:** assert rst_ni low during INNER of output 2.
  - All outputs read 0 asynchronously.
  - A restart reproduces the basic-convolution results exactly.
